// File: rtl/led_sequencer.sv
// led_sequencer: four debounced buttons drive a gray/chase/bounce/hold LED pattern sequencer.
// Define LED_SEQ_PWM_EN to dim the LED bank with an 8-bit PWM of on-count PWM_DUTY.
module led_sequencer #(
  parameter int LOG2DELAY     = 22,
  parameter int DEBOUNCE_BITS = 16,
  parameter int PWM_DUTY      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [4:0] led,
  output logic       ledg,
  output logic       ledr,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {GRAY = 2'd0, CHASE = 2'd1, BOUNCE = 2'd2, HOLD = 2'd3} mode_t;

  if (PWM_DUTY < 0 || PWM_DUTY > 255) begin : g_bad_duty
    $error("PWM_DUTY must fit in 8 bits");
  end

  logic [3:0]               sync1, sync2, deb, deb_d, press;
  logic [DEBOUNCE_BITS-1:0] stab_cnt [4];
  logic [LOG2DELAY-1:0]     presc;
  logic                     tick, advance;
  mode_t                    state, next_mode;
  logic [4:0]               step, step_adv, pattern, hold_pat, led_pat;
  logic                     run;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // A new level is accepted only after it has differed from the debounced value for 2^DEBOUNCE_BITS samples in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 4; i++) stab_cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          stab_cnt[i] <= '0;
        end else if (&stab_cnt[i]) begin
          deb[i]      <= sync2[i];
          stab_cnt[i] <= '0;
        end else begin
          stab_cnt[i] <= stab_cnt[i] + DEBOUNCE_BITS'(1);
        end
      end
    end
  end

  assign press = deb & ~deb_d;

  always_ff @(posedge clk) begin
    if (rst) presc <= '0;
    else     presc <= presc + LOG2DELAY'(1);
  end

  assign tick    = &presc;
  assign advance = (state != HOLD) && ((tick && run) || (press[2] && !run));

  always_comb begin
    step_adv = step + 5'd1;
    case (state)
      CHASE:   if (step >= 5'd4) step_adv = '0;
      BOUNCE:  if (step >= 5'd7) step_adv = '0;
      HOLD:    step_adv = step;
      default: step_adv = step + 5'd1;
    endcase
  end

  always_comb begin
    case (state)
      GRAY:    next_mode = CHASE;
      CHASE:   next_mode = BOUNCE;
      BOUNCE:  next_mode = HOLD;
      default: next_mode = GRAY;
    endcase
  end

  // Bounce walks the lit LED out to bit 4 and back over an 8-step cycle
  always_comb begin
    pattern = '0;
    case (state)
      GRAY:  pattern = step ^ (step >> 1);
      CHASE: pattern = 5'b00001 << step[2:0];
      BOUNCE: begin
        case (step[2:0])
          3'd0:    pattern = 5'b00001;
          3'd1:    pattern = 5'b00010;
          3'd2:    pattern = 5'b00100;
          3'd3:    pattern = 5'b01000;
          3'd4:    pattern = 5'b10000;
          3'd5:    pattern = 5'b01000;
          3'd6:    pattern = 5'b00100;
          default: pattern = 5'b00010;
        endcase
      end
      default: pattern = hold_pat;
    endcase
  end

  // Clear and mode both zero the step; clear wins over mode only for the held pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= GRAY;
      step     <= '0;
      run      <= 1'b1;
      hold_pat <= '0;
      led_pat  <= '0;
      ledg     <= 1'b1;
      ledr     <= 1'b0;
    end else begin
      led_pat <= pattern;
      ledg    <= run;
      ledr    <= |deb;
      if (press[1]) run <= ~run;
      if (press[0]) state <= next_mode;
      if (press[3] || press[0]) step <= '0;
      else if (advance)         step <= step_adv;
      if (press[3] && (state == HOLD || (press[0] && state == BOUNCE))) hold_pat <= '0;
      else if (press[0] && state == BOUNCE)                             hold_pat <= pattern;
    end
  end

  assign mode = state;

`ifdef LED_SEQ_PWM_EN
  logic [7:0] pwm_cnt;
  logic       pwm_on;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign pwm_on = {1'b0, pwm_cnt} < 9'(PWM_DUTY);
  assign led    = led_pat & {5{pwm_on}};
`else
  assign led = led_pat;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: table vectors, hand-written corner sequences and a randomized run
// checked every cycle against a behavioural model of the sequencer.
module tb_led_sequencer;

  localparam int PWM_DUTY = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'h0;
  logic [4:0] led;
  logic       ledg, ledr;
  logic [1:0] mode;

  int checks   = 0;
  int failures = 0;

  led_sequencer #(.LOG2DELAY(4), .DEBOUNCE_BITS(3), .PWM_DUTY(PWM_DUTY)) dut (
    .clk(clk), .rst(rst), .btn(btn), .led(led), .ledg(ledg), .ledr(ledr), .mode(mode)
  );

  always #5 clk = ~clk;

  // Behavioural model state: plain integers, run lengths and modulo arithmetic
  logic [3:0] m_h1, m_h2, m_deb, m_deb_old;
  int         m_run_len [4];
  int         m_mode, m_step, m_held, m_presc, m_since_rst;
  bit         m_run;
  logic [4:0] exp_led;
  bit         exp_ledg, exp_ledr;
  int         exp_mode;
  bit         model_on = 1'b0;
  int         model_fail_prints = 0;

  function automatic int pattern_of(int md, int st, int held);
    int bounce_pos [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    case (md)
      0:       return st ^ (st >> 1);
      1:       return 1 << st;
      2:       return 1 << bounce_pos[st % 8];
      default: return held;
    endcase
  endfunction

  function automatic int range_of(int md);
    case (md)
      0:       return 32;
      1:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic logic [4:0] gate(logic [4:0] v);
`ifdef LED_SEQ_PWM_EN
    return ((m_since_rst % 256) < PWM_DUTY) ? v : 5'd0;
`else
    return v;
`endif
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] view, pr;
    bit         tk, adv;
    if (rst) begin
      m_h1 = 0; m_h2 = 0; m_deb = 0; m_deb_old = 0;
      for (int i = 0; i < 4; i++) m_run_len[i] = 0;
      m_mode = 0; m_step = 0; m_held = 0; m_presc = 0; m_since_rst = 0; m_run = 1;
      exp_led = 0; exp_ledg = 1; exp_ledr = 0; exp_mode = 0;
      model_on = 1;
    end else begin
      m_since_rst++;
      exp_led  = gate(5'(pattern_of(m_mode, m_step, m_held)));
      exp_ledg = m_run;
      exp_ledr = |m_deb;
      pr = m_deb & ~m_deb_old;
      tk = (m_presc == 15);
      m_presc = (m_presc + 1) % 16;
      adv = (m_mode != 3) && ((tk && m_run) || (pr[2] && !m_run));
      if (pr[3] && (m_mode == 3 || (pr[0] && m_mode == 2))) m_held = 0;
      else if (pr[0] && m_mode == 2) m_held = pattern_of(2, m_step, 0);
      if (pr[3] || pr[0]) m_step = 0;
      else if (adv)       m_step = (m_step + 1) % range_of(m_mode);
      if (pr[0]) m_mode = (m_mode + 1) % 4;
      if (pr[1]) m_run = !m_run;
      view = m_h2; m_h2 = m_h1; m_h1 = btn;
      m_deb_old = m_deb;
      for (int i = 0; i < 4; i++) begin
        if (view[i] != m_deb[i]) begin
          m_run_len[i]++;
          if (m_run_len[i] == 8) begin
            m_deb[i] = view[i];
            m_run_len[i] = 0;
          end
        end else begin
          m_run_len[i] = 0;
        end
      end
      exp_mode = m_mode;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      checks++;
      if (led !== exp_led || ledg !== exp_ledg || ledr !== exp_ledr || mode !== 2'(exp_mode)) begin
        failures++;
        if (model_fail_prints < 20) begin
          model_fail_prints++;
          $display("[TB] FAIL model t=%0t: led=%b ledg=%b ledr=%b mode=%0d, required led=%b ledg=%b ledr=%b mode=%0d",
                   $time, led, ledg, ledr, mode, exp_led, exp_ledg, exp_ledr, exp_mode);
        end
      end
    end
  end

  typedef struct {
    bit         do_rst;
    logic [3:0] btn;
    int         cycles;
    logic [4:0] led;
    bit         ledg;
    bit         ledr;
    logic [1:0] mode;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, logic [3:0] b, int n, logic [4:0] l, bit g, bit rr, logic [1:0] m);
    vec_t v;
    v.do_rst = r; v.btn = b; v.cycles = n; v.led = l; v.ledg = g; v.ledr = rr; v.mode = m;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(logic [3:0] b, int n);
    btn = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(string name, logic [4:0] l, bit g, bit r, logic [1:0] m);
    logic [4:0] lg;
    lg = gate(l);
    checks++;
    if (led !== lg || ledg !== g || ledr !== r || mode !== m) begin
      failures++;
      $display("[TB] FAIL %s: led=%b ledg=%b ledr=%b mode=%0d, required led=%b ledg=%b ledr=%b mode=%0d",
               name, led, ledg, ledr, mode, lg, g, r, m);
    end
  endtask

  task automatic checkValue(string name, int actual, int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  task automatic waitLed(string name, logic [4:0] want, int budget);
    int n;
    n = 0;
    while (led !== want && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (led !== want) begin
      failures++;
      $display("[TB] FAIL %s: led=%b, required %b within %0d cycles", name, led, want, budget);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    btn = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset", 5'd0, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic pressBtn(logic [3:0] b);
    applyStimulus(b, 12);
    applyStimulus(4'h0, 12);
  endtask

  initial begin
    // Gray sequence from reset, one step per 16 cycles
    add(1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 16, 5'd0, 1, 0, 0);
    add(0, 0, 1, 5'd1, 1, 0, 0);
    add(0, 0, 16, 5'd3, 1, 0, 0);
    add(0, 0, 16, 5'd2, 1, 0, 0);
    add(0, 0, 16, 5'd6, 1, 0, 0);
    add(0, 0, 16, 5'd7, 1, 0, 0);
    add(0, 0, 16, 5'd5, 1, 0, 0);
    add(0, 0, 16, 5'd4, 1, 0, 0);
    add(0, 0, 16, 5'd12, 1, 0, 0);
    // Chattering mode button: exactly one increment to CHASE
    add(1, 0, 0, 0, 1, 0, 0);
    add(0, 4'h1, 1, 5'd0, 1, 0, 0);
    add(0, 4'h0, 1, 5'd0, 1, 0, 0);
    add(0, 4'h1, 1, 5'd0, 1, 0, 0);
    add(0, 4'h1, 9, 5'd0, 1, 0, 0);
    add(0, 4'h1, 1, 5'd0, 1, 1, 1);
    add(0, 4'h1, 1, 5'd1, 1, 1, 1);
    add(0, 4'h1, 2, 5'd1, 1, 1, 1);
    add(0, 4'h1, 1, 5'd2, 1, 1, 1);
    add(0, 4'h1, 6, 5'd2, 1, 1, 1);
    add(0, 4'h0, 10, 5'd4, 1, 1, 1);
    add(0, 4'h0, 1, 5'd4, 1, 0, 1);
    add(0, 4'h0, 16, 5'd8, 1, 0, 1);
    // Clear and mode debounced together at step 9
    add(1, 0, 0, 0, 1, 0, 0);
    add(0, 4'h0, 139, 5'd12, 1, 0, 0);
    add(0, 4'h9, 11, 5'd13, 1, 1, 1);
    add(0, 4'h9, 1, 5'd1, 1, 1, 1);
    add(0, 4'h0, 10, 5'd2, 1, 1, 1);
    add(0, 4'h0, 1, 5'd2, 1, 0, 1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) resetDut();
      else begin
        applyStimulus(vecs[i].btn, vecs[i].cycles);
        checkOutput($sformatf("vec%0d", i), vecs[i].led, vecs[i].ledg, vecs[i].ledr, vecs[i].mode);
      end
    end

    // A 5-cycle pulse is too short to be accepted
    resetDut();
    applyStimulus(4'h1, 5);
    applyStimulus(4'h0, 20);
    checkValue("short_pulse_mode", int'(mode), 0);

    // Pause, then single-step three times from step 0
    resetDut();
    applyStimulus(4'h2, 12);
    applyStimulus(4'h0, 12);
    checkValue("paused_ledg", int'(ledg), 0);
    applyStimulus(4'h0, 40);
    repeat (3) pressBtn(4'h4);
    checkValue("three_steps_led", int'(led), int'(gate(5'd2)));
    pressBtn(4'h2);
    checkValue("resumed_ledg", int'(ledg), 1);
    pressBtn(4'h4);

    // Hold latches, clear in hold blanks, mode wraps to gray
    resetDut();
    repeat (3) pressBtn(4'h1);
    checkValue("hold_mode", int'(mode), 3);
    applyStimulus(4'h0, 40);
    pressBtn(4'h8);
    checkValue("hold_clear_led", int'(led), 0);
    checkValue("hold_clear_mode", int'(mode), 3);
    pressBtn(4'h1);
    checkValue("wrap_mode", int'(mode), 0);

`ifndef LED_SEQ_PWM_EN
    // Bounce visits 0,1,2,3,4,3,2,1 and wraps to 0
    resetDut();
    pressBtn(4'h1);
    pressBtn(4'h1);
    checkValue("bounce_mode", int'(mode), 2);
    waitLed("bounce_start", 5'b00001, 200);
    waitLed("bounce_1", 5'b00010, 20);
    waitLed("bounce_2", 5'b00100, 20);
    waitLed("bounce_3", 5'b01000, 20);
    waitLed("bounce_4", 5'b10000, 20);
    waitLed("bounce_5", 5'b01000, 20);
    waitLed("bounce_6", 5'b00100, 20);
    waitLed("bounce_7", 5'b00010, 20);
    waitLed("bounce_wrap", 5'b00001, 20);
`endif

    // Randomized buttons with occasional mid-sequence resets
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 19) == 0) resetDut();
      else applyStimulus(4'($urandom_range(0, 15)), int'($urandom_range(1, 24)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter LOG2DELAY, default 22, meaning the step period is 2^LOG2DELAY clk cycles.
REQ-002 SHALL have parameter DEBOUNCE_BITS, default 16, meaning a raw button level must be stable for 2^DEBOUNCE_BITS cycles before it is accepted.
REQ-003 SHALL have parameter PWM_DUTY, default 64, meaning the 8-bit PWM on-count (used only under LED_SEQ_PWM_EN).
REQ-004 SHALL have port clk, input, 1, system clock; it is the only clock.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port btn, input, 4, raw active-high buttons (asynchronous): [0] mode, [1] run/pause, [2] single-step, [3] clear.
REQ-007 SHALL have port led, output, 5, LED bank pattern.
REQ-008 SHALL have ports ledg and ledr, output, 1 each: ledg is the run flag, ledr is any-button-held.
REQ-009 SHALL have port mode, output, 2, current mode: 0 GRAY, 1 CHASE, 2 BOUNCE, 3 HOLD.

Function
REQ-010 SHALL pass each btn bit through a 2-flop synchronizer, then a per-button stability counter; the debounced level takes the synchronized value after 2^DEBOUNCE_BITS consecutive equal samples, and any mismatch restarts the count.
REQ-011 SHALL generate a one-cycle press pulse per button on the cycle after its debounced level rises; releases generate no event.
REQ-012 SHALL run a free-running LOG2DELAY-bit prescaler, cleared only by rst, that emits a one-cycle tick at wrap; mode and button events do not disturb it.
REQ-013 SHALL hold a 5-bit step counter with a mode-dependent range: GRAY 0..31, CHASE 0..4, BOUNCE 0..7; the counter wraps to 0 past the top of its range.
REQ-014 SHALL advance step on tick only when run=1 and mode!=HOLD.
REQ-015 SHALL, on a btn[2] press with run=0 and mode!=HOLD, advance step by one; the press SHALL be ignored while run=1.
REQ-016 SHALL treat a tick and a single-step in the same cycle as a single advance.
REQ-017 SHALL toggle run on a btn[1] press.
REQ-018 SHALL, on a btn[0] press, set mode to (mode+1) mod 4 and clear step to 0; on entry to HOLD the current led value is latched and held.
REQ-019 SHALL clear step to 0 on a btn[3] press; in HOLD this also sets the held pattern to 5'b00000.
REQ-020 SHALL resolve simultaneous press events with priority btn[3] > btn[0] > btn[1] > btn[2]; run toggling (btn[1]) is independent and applies in the same cycle as any other event.
REQ-021 SHALL decode led as a register updated one cycle after step/mode change: GRAY gives step^(step>>1); CHASE gives one-hot bit[step]; BOUNCE gives one-hot at position {0,1,2,3,4,3,2,1}[step]; HOLD gives the latched value.
REQ-022 SHALL drive ledg = run and ledr = OR of the debounced levels, both registered.
REQ-023 SHALL drive the mode output directly from the state register.

Reset
REQ-024 SHALL, when rst is high at a clk edge, set: mode=GRAY, step=0, run=1, prescaler=0, synchronizers/debounced levels/counters=0, led=5'b00000, ledg=1, ledr=0.
REQ-025 SHALL let rst asserted mid-debounce or mid-step discard all pending events, with no press pulse on the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, when LED_SEQ_PWM_EN is defined, gate every led bit with an 8-bit free-running PWM that is high while pwm_cnt < PWM_DUTY; PWM_DUTY=0 gives all LEDs off and PWM_DUTY=255 gives 255/256 on; ledr and ledg are not gated.
REQ-027 SHALL, when LED_SEQ_PWM_EN is undefined, drive led straight from the pattern register, with no PWM logic present.

Verification (LOG2DELAY=4, DEBOUNCE_BITS=3, PWM macro undefined unless stated)
REQ-028 Reset, then 16*8 cycles idle -> led follows gray 0,1,3,2,6,7,5,4, changing every 16 cycles; ledg=1; mode=0.
REQ-029 btn[0] held 20 cycles, with 3 cycles of 1/0 chatter before it -> exactly one mode increment to 1 (CHASE), step=0, led=00001, then 00010 after the next tick; pulses shorter than 8 cycles produce no event.
REQ-030 Mode BOUNCE, run=1, 8 ticks -> led one-hot positions 0,1,2,3,4,3,2,1, then wraps to 0.
REQ-031 btn[1] press, then btn[2] pressed 3 times -> ticks are ignored, step advances by exactly 3, ledg=0; btn[2] while running -> no change.
REQ-032 btn[3] and btn[0] debounced on the same cycle in GRAY with step=9 -> mode=1, step=0, led=00001, run unchanged.
REQ-033 Macro defined, PWM_DUTY=64, pattern 11111 -> each led bit is high 64 of every 256 cycles; rst pulsed mid-sequence -> REQ-024 values on the next cycle.
